// File: rtl/bcd_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int BCD_DIGIT_W = 4;

  function automatic int cnt_w(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

  // Decimal digits needed to represent v (0 still needs one digit).
  function automatic int min_digits(input int v);
    int n;
    int r;
    n = 1;
    r = v;
    while (r >= 10) begin
      r = r / 10;
      n = n + 1;
    end
    return n;
  endfunction
endpackage

// File: rtl/seq_bin_to_bcd_if.sv
// Start/busy/done handshake and result bus of the binary-to-BCD converter.
interface seq_bin_to_bcd_if #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  sat;

  modport master (output start, bin_in, input busy, done, bcd_out, sat);
  modport slave  (input start, bin_in, output busy, done, bcd_out, sat);
endinterface

// File: rtl/bcd_add3_digit.sv
// One double-dabble correction: a BCD digit of 5 or more gets +3 before the shift.
import bcd_pkg::*;

module bcd_add3_digit (
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BCD_DIGIT_W-1:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/seq_bin_to_bcd.sv
// Iterative shift-add-3 converter, one operand bit per clock, optional input clamp.
import bcd_pkg::*;

module seq_bin_to_bcd #(
  parameter int BIN_W   = 10,
  parameter int DIGITS  = 4,
  parameter int SAT_EN  = 1,
  parameter int SAT_MAX = 511
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_bin_to_bcd_if.slave bus
);
  localparam int CNT_W = cnt_w(BIN_W);
  localparam int MAXV  = (SAT_EN != 0) ? SAT_MAX : (1 << BIN_W) - 1;
  localparam int TOT_W = BCD_DIGIT_W*DIGITS + BIN_W;
  localparam logic [BIN_W-1:0] SAT_V   = BIN_W'(SAT_MAX);
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(BIN_W - 1);

  if (BIN_W < 1 || BIN_W > 20) begin : g_bad_w
    $fatal(1, "seq_bin_to_bcd: BIN_W out of range 1..20");
  end
  if (SAT_EN != 0 && (SAT_MAX < 0 || SAT_MAX >= (1 << BIN_W))) begin : g_bad_sat
    $fatal(1, "seq_bin_to_bcd: SAT_MAX does not fit in BIN_W bits");
  end
  if (DIGITS < min_digits(MAXV)) begin : g_bad_digits
    $fatal(1, "seq_bin_to_bcd: DIGITS too small for the largest operand");
  end

  state_t                            state;
  logic [BIN_W-1:0]                  opnd;
  logic [DIGITS-1:0][BCD_DIGIT_W-1:0] scr;
  logic [DIGITS-1:0][BCD_DIGIT_W-1:0] adj;
  logic [CNT_W-1:0]                  cnt;
  logic                              sat_pend;
  logic                              over;
  logic [TOT_W-1:0]                  shifted;

  assign over    = (SAT_EN != 0) && (bus.bin_in > SAT_V);
  assign shifted = {adj, opnd} << 1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3_digit u_add3 (.d(scr[i]), .q(adj[i]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      opnd        <= '0;
      scr         <= '0;
      cnt         <= '0;
      sat_pend    <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.bcd_out <= '0;
      bus.sat     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          opnd     <= over ? SAT_V : bus.bin_in;
          sat_pend <= over;
          scr      <= '0;
          cnt      <= '0;
          bus.busy <= 1'b1;
          state    <= SHIFT;
        end
        SHIFT: begin
          {scr, opnd} <= shifted;
          cnt         <= cnt + 1'b1;
          if (cnt == LAST_IT) state <= DONE;
        end
        DONE: begin
          // Outputs change only here, so the display mux never sees partial sums.
          bus.bcd_out <= scr;
          bus.sat     <= sat_pend;
          bus.done    <= 1'b1;
          bus.busy    <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
